pll_lock_sequencer: RTL



---
 rtl/pll_lock_sequencer_pkg.sv | 28 ++
 rtl/pll_lock_sequencer_sync_2ff.sv | 23 ++
 rtl/pll_lock_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and default constants for the PLL lock sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  localparam int unsigned DEF_RST_PULSE_CYCLES    = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;  // 1 ms at 50 MHz
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_MAX_RETRIES         = 3;

  // Counter width: enough bits for the largest cycle parameter, never zero.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Generic 1-bit two-flop synchronizer for asynchronous status inputs.
// Both stages clear on the synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops to settle metastability on d.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: pulses the PLL reset, waits for lock with timeout and
// bounded retries, debounces lock, then releases the downstream system reset.
// Optional build macro: PLL_SEQ_LOSS_COUNT_EN enables the saturating
// lost-lock event counter on loss_cnt (tied to zero otherwise).
//
// The FSM state is the internal signal `state` (type pll_state_e).
// All outputs are registered and decoded from state_nxt, so they change on the
// same refclk edge as the state. locked_s is itself a register, so the FSM
// reacts to a change of locked_s on the edge after locked_s changes.
// relock_req is a level sampled each cycle; it acts only in RUN and FAIL.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          refclk,
  input  logic          rst_n,
  input  logic          locked,
  input  logic          relock_req,
  output logic          pll_rst,
  output logic          sys_rst_n,
  output logic          ready,
  output logic          fail,
  output logic [RW-1:0] retry_cnt,
  output logic [7:0]    loss_cnt
);

  localparam int unsigned CNT_W =
    cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RW-1:0]    RETRY_MAX    = RW'(MAX_RETRIES);

  pll_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [RW-1:0]    retry_nxt;
  logic             locked_s;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  // Next-state, counter and retry decisions for the sequencer.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    unique case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      WAIT_LOCK: begin
        // Lock seen on the timeout cycle still wins over a retry.
        if (locked_s) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          cnt_nxt = '0;
          if (retry_cnt == RETRY_MAX) begin
            state_nxt = FAIL;
          end else begin
            state_nxt = RESET_PLL;
            retry_nxt = retry_cnt + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        // Lost lock and relock request share one transition.
        if (!locked_s || relock_req) begin
          state_nxt = RESET_PLL;
          cnt_nxt   = '0;
        end
      end
      FAIL: begin
        if (relock_req) begin
          state_nxt = RESET_PLL;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = RESET_PLL;
        cnt_nxt   = '0;
        retry_nxt = '0;
      end
    endcase
  end

  // State, counters and outputs registered together; outputs decode next state.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      pll_rst   <= (state_nxt == RESET_PLL) || (state_nxt == FAIL);
      sys_rst_n <= (state_nxt == RUN);
      ready     <= (state_nxt == RUN);
      fail      <= (state_nxt == FAIL);
    end
  end

`ifdef PLL_SEQ_LOSS_COUNT_EN
  logic loss_evt;
  assign loss_evt = (state == RUN) && !locked_s;

  // Saturating count of RUN exits caused by lost lock; cleared only by rst_n.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      loss_cnt <= 8'd0;
    end else if (loss_evt && (loss_cnt != 8'hff)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`else
  assign loss_cnt = 8'd0;
`endif

endmodule
